chip_checker_key_debounce: RTL and testbench

//   Conditions the raw push-button KEY pins before they reach the key PIO input port.
//   Per key bit:
//   - two-flop synchroniser, then a consecutive-sample debounce counter;
//   - outputs a clean, active-high "pressed" level;
//   - outputs one-cycle press/release pulses;
//   - holds a sticky press-capture flag that software/FSM logic clears.

---
 rtl/chip_checker_key_debounce_if.sv | 30 +++
 rtl/chip_checker_key_debounce.sv | 79 +++++++
 tb/tb_chip_checker_key_debounce.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/chip_checker_key_debounce_if.sv
// Key conditioning bus: raw pins and capture clears in, debounced level/pulses/capture out.
// The debouncer has no backpressure, so the bus carries plain levels with no handshake.
interface chip_checker_key_debounce_if #(
  parameter int WIDTH = 2
) ();
  logic [WIDTH-1:0] key_raw;
  logic [WIDTH-1:0] capture_clr;
  logic [WIDTH-1:0] key_pressed;
  logic [WIDTH-1:0] key_press;
  logic [WIDTH-1:0] key_release;
  logic [WIDTH-1:0] key_capture;

  modport master (
    output key_raw,
    output capture_clr,
    input  key_pressed,
    input  key_press,
    input  key_release,
    input  key_capture
  );

  modport slave (
    input  key_raw,
    input  capture_clr,
    output key_pressed,
    output key_press,
    output key_release,
    output key_capture
  );
endinterface

// File: rtl/chip_checker_key_debounce.sv
// Per-key synchroniser + debounce counter with press/release pulses and a sticky capture flag.
// A held pin change is accepted DEBOUNCE+2 edges later; there is no backpressure, inputs are levels.
module chip_checker_key_debounce #(
  parameter int WIDTH      = 2,
  parameter int DEBOUNCE   = 50000,
  parameter int CNT_BITS   = 16,
  parameter int ACTIVE_LOW = 1
) (
  input logic                          clk,
  input logic                          reset,
  chip_checker_key_debounce_if.slave   kif
);

  localparam logic                ACT     = (ACTIVE_LOW != 0);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] pressed_q, pressed_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [WIDTH-1:0] norm;
  logic [WIDTH-1:0] fire;
  logic [WIDTH-1:0][CNT_BITS-1:0] cnt_q, cnt_d;

  // Synchronisers reset to the unpressed pin level so no spurious count starts after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= {WIDTH{ACT}};
      sync2_q   <= {WIDTH{ACT}};
      pressed_q <= '0;
      press_q   <= '0;
      release_q <= '0;
      capture_q <= '0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      capture_q <= capture_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    sync1_d   = kif.key_raw;
    sync2_d   = sync1_q;
    norm      = sync2_q ^ {WIDTH{ACT}};
    pressed_d = pressed_q;
    cnt_d     = cnt_q;
    fire      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (norm[i] == pressed_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        fire[i]      = 1'b1;
        pressed_d[i] = norm[i];
        cnt_d[i]     = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
      end
    end
    press_d   = fire & norm;
    release_d = fire & ~norm;
    // A press in flight beats a simultaneous clear so no press is ever lost.
    capture_d = press_q | (capture_q & ~kif.capture_clr);
  end

  always_comb begin
    kif.key_pressed = pressed_q;
    kif.key_press   = press_q;
    kif.key_release = release_q;
    kif.key_capture = capture_q;
  end

endmodule

// File: tb/tb_chip_checker_key_debounce.sv
// Directed + randomized bench for chip_checker_key_debounce with DEBOUNCE=4.
// Reference model decides acceptance from a window of past synchronised pin samples.
module tb_chip_checker_key_debounce;

  localparam int D    = 4;
  localparam int MAXE = 4096;

  logic       clk;
  logic       rst;
  logic [1:0] raw;
  logic [1:0] clr;

  int tests;
  int fails;

  chip_checker_key_debounce_if #(.WIDTH(2)) kif ();

  assign kif.key_raw     = raw;
  assign kif.capture_clr = clr;

  chip_checker_key_debounce #(
    .WIDTH(2), .DEBOUNCE(D), .CNT_BITS(16), .ACTIVE_LOW(1)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .kif   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: history of pins and resets per edge, last acceptance/reset edge per bit.
  logic [1:0] raw_at [0:MAXE-1];
  logic       rst_at [0:MAXE-1];
  int         e;
  int         last_acc [2];
  logic [1:0] m_pressed, m_press, m_release, m_capture;

  // Pressed-normalised sample seen by the debouncer at edge j (idle while reset flushes sync).
  function automatic logic samp(input int j, input int i);
    logic [1:0] r;
    if (j < 3) return 1'b0;
    if (rst_at[j-1] || rst_at[j-2]) return 1'b0;
    r = raw_at[j-2];
    return ~r[i];
  endfunction

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [1:0] np, nr;
    logic       ok;
    @(posedge clk);
    e++;
    if (e >= MAXE) begin
      $display("FAIL edge_budget: observed=%0d expected<%0d", e, MAXE);
      $fatal(1, "edge budget exhausted");
    end
    raw_at[e] = raw;
    rst_at[e] = rst;
    if (rst) begin
      m_pressed = '0; m_press = '0; m_release = '0; m_capture = '0;
      last_acc[0] = e; last_acc[1] = e;
    end else begin
      m_capture = m_press | (m_capture & ~clr);
      np = '0; nr = '0;
      for (int i = 0; i < 2; i++) begin
        if (e - last_acc[i] >= D) begin
          ok = 1'b1;
          for (int k = 0; k < D; k++)
            if (samp(e - k, i) == m_pressed[i]) ok = 1'b0;
          if (ok) begin
            m_pressed[i] = ~m_pressed[i];
            if (m_pressed[i]) np[i] = 1'b1;
            else              nr[i] = 1'b1;
            last_acc[i] = e;
          end
        end
      end
      m_press   = np;
      m_release = nr;
    end
    #1;
    chk("model_pressed", kif.key_pressed, m_pressed);
    chk("model_press",   kif.key_press,   m_press);
    chk("model_release", kif.key_release, m_release);
    chk("model_capture", kif.key_capture, m_capture);
  endtask

  initial begin
    tests = 0; fails = 0; e = 0;
    last_acc[0] = 0; last_acc[1] = 0;
    m_pressed = '0; m_press = '0; m_release = '0; m_capture = '0;
    for (int k = 0; k < MAXE; k++) begin raw_at[k] = 2'b11; rst_at[k] = 1'b0; end
    rst_at[0] = 1'b1;
    rst = 1'b1; raw = 2'b11; clr = 2'b00;

    // Reset state and quiet idle.
    repeat (3) step();
    chk("rst_pressed", kif.key_pressed, 2'b00);
    chk("rst_press",   kif.key_press,   2'b00);
    chk("rst_release", kif.key_release, 2'b00);
    chk("rst_capture", kif.key_capture, 2'b00);
    rst = 1'b0;
    repeat (20) step();
    chk("idle_pressed", kif.key_pressed, 2'b00);

    // Clean press on bit 0: accepted on edge 6 after the change.
    raw[0] = 1'b0;
    repeat (5) step();
    chk("lat_early_pressed", kif.key_pressed, 2'b00);
    step();
    chk("lat_pressed", kif.key_pressed, 2'b01);
    chk("lat_press",   kif.key_press,   2'b01);
    step();
    chk("capture_set", kif.key_capture, 2'b01);
    chk("press_1cyc",  kif.key_press,   2'b00);

    // Bounce on bit 1: never qualifies.
    for (int k = 0; k < 14; k++) begin
      raw[1] = (k == 3 || k >= 7);
      step();
      chk("bounce_pressed1", {1'b0, kif.key_pressed[1]}, 2'b00);
      chk("bounce_press1",   {1'b0, kif.key_press[1]},   2'b00);
    end

    // Release bit 0.
    raw[0] = 1'b1;
    repeat (5) step();
    chk("rel_early", kif.key_release, 2'b00);
    step();
    chk("rel_pulse",   kif.key_release, 2'b01);
    chk("rel_pressed", kif.key_pressed, 2'b00);
    chk("rel_capture", kif.key_capture, 2'b01);
    step();
    chk("rel_1cyc", kif.key_release, 2'b00);

    // Clear capture, then race a clear against a new press.
    clr = 2'b01;
    step();
    chk("clr_capture", kif.key_capture, 2'b00);
    clr = 2'b00;
    raw[0] = 1'b0;
    repeat (6) step();
    chk("race_press", kif.key_press, 2'b01);
    clr = 2'b01;
    step();
    chk("set_wins", kif.key_capture, 2'b01);
    step();
    chk("clr_after", kif.key_capture, 2'b00);
    step();
    chk("clr_on_zero", kif.key_capture, 2'b00);
    clr = 2'b00;

    // Reset in the middle of a press qualification.
    raw[0] = 1'b1;
    repeat (8) step();
    raw[0] = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_pressed", kif.key_pressed, 2'b00);
    chk("midrst_press",   kif.key_press,   2'b00);
    repeat (5) step();
    chk("postrst_early", kif.key_pressed, 2'b00);
    step();
    chk("postrst_pressed", kif.key_pressed, 2'b01);
    chk("postrst_press",   kif.key_press,   2'b01);

    // Randomized pin activity, clears and occasional resets.
    for (int s = 0; s < 80; s++) begin
      int len;
      raw = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        clr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        rst = ($urandom_range(0, 49) == 0);
        step();
      end
    end
    rst = 1'b0; clr = 2'b00;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
